// File: rtl/iter_alu_responder.sv
// Multi-cycle Y86-64 OPq execute unit (ADD/SUB/AND/XOR) behind a request/response handshake.
// Each BUSY cycle processes one CHUNK-wide slice, and the carry is held between cycles.
module iter_alu_responder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_ifun,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zf,
    output logic             rsp_sf,
    output logic             rsp_of,
    output logic             rsp_err
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR} op_t;

    state_t           r_state;
    op_t              r_op;
    logic             r_inv;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;
    logic             r_err;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_a_op;
    logic [CHUNK:0]   w_sum;
    logic [CHUNK-1:0] w_chunk;
    logic [WIDTH-1:0] w_next_acc;
    logic             w_last;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_a_chunk  = '0;
        w_b_chunk  = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end

        // Subtraction is b + ~a + 1, with the +1 entering as the initial carry.
        w_a_op = (r_op == OP_SUB) ? ~w_a_chunk : w_a_chunk;
        w_sum  = {1'b0, w_b_chunk} + {1'b0, w_a_op} + {{CHUNK{1'b0}}, r_carry};

        unique case (r_op)
            OP_AND:  w_chunk = w_a_chunk & w_b_chunk;
            OP_XOR:  w_chunk = w_a_chunk ^ w_b_chunk;
            default: w_chunk = w_sum[CHUNK-1:0];
        endcase

        w_next_acc = r_acc;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_cnt == CW'(i)) begin
                w_next_acc[i*CHUNK +: CHUNK] = w_chunk;
            end
        end

        w_last = (r_cnt == CW'(NCHUNK - 1));
        w_zf   = (w_next_acc == '0);
        w_sf   = w_next_acc[WIDTH-1];
        unique case (r_op)
            OP_ADD:  w_of = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_next_acc[WIDTH-1] != r_a[WIDTH-1]);
            OP_SUB:  w_of = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_next_acc[WIDTH-1] != r_b[WIDTH-1]);
            default: w_of = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= OP_ADD;
            r_inv        <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_carry      <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_zf         <= 1'b0;
            r_sf         <= 1'b0;
            r_of         <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_op        <= op_t'(req_ifun[1:0]);
                        r_inv       <= |req_ifun[3:2];
                        r_cnt       <= '0;
                        r_carry     <= (req_ifun == 4'd1);
                        r_req_ready <= 1'b0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Invalid functions spend a single BUSY cycle, then respond with an error.
                    if (r_inv) begin
                        r_rsp_result <= '0;
                        r_zf         <= 1'b0;
                        r_sf         <= 1'b0;
                        r_of         <= 1'b0;
                        r_err        <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_acc   <= w_next_acc;
                        r_carry <= w_sum[CHUNK];
                        r_cnt   <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_rsp_result <= w_next_acc;
                            r_zf         <= w_zf;
                            r_sf         <= w_sf;
                            r_of         <= w_of;
                            r_err        <= 1'b0;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zf     = r_zf;
    assign rsp_sf     = r_sf;
    assign rsp_of     = r_of;
    assign rsp_err    = r_err;

endmodule
